// File: rtl/fractal_axis_out.sv
// AXI4-Stream output stage for the fractal colorizer: FIFO with output register,
// almost-full throttle to the upstream pipeline and frame-level overflow recovery.
module fractal_axis_out #(
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [23:0] data_in,
    input  logic        frame_start_in,
    input  logic        line_end_in,
    input  logic        data_enable_in,
    output logic        ready_out,
    output logic [23:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tuser,
    output logic        m_axis_tlast,
    output logic        overflow,
    input  logic        clear_overflow,
    output logic [15:0] frame_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LEVEL = CW'(DEPTH - AF_MARGIN);

    typedef enum logic [1:0] {WAIT_SOF, PASS, DROP} state_t;

    state_t          state, state_next;
    logic [25:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   mem_count, mem_count_next, occ, occ_next;
    logic            rd, space, wr_en, drop_full;
    logic            load_out, mem_empty, mem_pop, mem_push, direct, vld_next;
    logic [25:0]     beat_p0;

    assign beat_p0 = {line_end_in, frame_start_in, data_in};

    // Storage holds at most DEPTH-1 entries; the output register is the last slot.
    always_comb begin
        rd         = m_axis_tvalid && m_axis_tready;
        occ        = mem_count + CW'(m_axis_tvalid);
        space      = (occ != DEPTH_C) || rd;
        wr_en      = 1'b0;
        drop_full  = 1'b0;
        state_next = state;
        if (data_enable_in) begin
            case (state)
                PASS: begin
                    if (space) begin
                        wr_en = 1'b1;
                    end else begin
                        drop_full  = 1'b1;
                        state_next = DROP;
                    end
                end
                WAIT_SOF, DROP: begin
                    if (frame_start_in) begin
                        if (space) begin
                            wr_en      = 1'b1;
                            state_next = PASS;
                        end else begin
                            drop_full  = 1'b1;
                            state_next = DROP;
                        end
                    end
                end
                default: state_next = WAIT_SOF;
            endcase
        end
        load_out       = !m_axis_tvalid || m_axis_tready;
        mem_empty      = (mem_count == '0);
        mem_pop        = load_out && !mem_empty;
        direct         = wr_en && load_out && mem_empty;
        mem_push       = wr_en && !direct;
        vld_next       = load_out ? (!mem_empty || wr_en) : 1'b1;
        mem_count_next = mem_count + CW'(mem_push) - CW'(mem_pop);
        occ_next       = mem_count_next + CW'(vld_next);
    end

    always_ff @(posedge clk) begin
        if (mem_push) begin
            mem[wr_ptr] <= beat_p0;
        end
    end

    // Output register stage: loads only when empty or handshaking, so AXI data stays stable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= WAIT_SOF;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            mem_count     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
            ready_out     <= 1'b1;
            overflow      <= 1'b0;
            frame_count   <= '0;
        end else begin
            state     <= state_next;
            mem_count <= mem_count_next;
            ready_out <= (occ_next <= AF_LEVEL);
            if (mem_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (mem_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (load_out) begin
                m_axis_tvalid <= vld_next;
                if (!mem_empty) begin
                    {m_axis_tlast, m_axis_tuser, m_axis_tdata} <= mem[rd_ptr];
                end else if (wr_en) begin
                    {m_axis_tlast, m_axis_tuser, m_axis_tdata} <= beat_p0;
                end
            end
            if (drop_full) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
            if (rd && m_axis_tuser) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fractal_axis_out.sv
// Self-checking bench for fractal_axis_out against a queue-based frame model.
module tb_fractal_axis_out;

    localparam int DEPTH     = 16;
    localparam int AF_MARGIN = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [23:0] data_in = '0;
    logic        frame_start_in = 1'b0;
    logic        line_end_in = 1'b0;
    logic        data_enable_in = 1'b0;
    logic        ready_out;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tuser;
    logic        m_axis_tlast;
    logic        overflow;
    logic        clear_overflow = 1'b0;
    logic [15:0] frame_count;

    fractal_axis_out #(.DEPTH(DEPTH), .AF_MARGIN(AF_MARGIN)) dut (
        .clk(clk), .resetn(resetn), .data_in(data_in), .frame_start_in(frame_start_in),
        .line_end_in(line_end_in), .data_enable_in(data_enable_in), .ready_out(ready_out),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .overflow(overflow),
        .clear_overflow(clear_overflow), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef enum {M_WAIT, M_PASS, M_DROP} mstate_t;

    logic [25:0] mq[$];
    mstate_t     m_st;
    logic        m_ovf, m_rdy;
    logic [15:0] m_fc;
    int          n_checks = 0, n_err = 0, hs_cnt = 0;

    task automatic model_reset();
        mq.delete();
        m_st = M_WAIT; m_ovf = 1'b0; m_rdy = 1'b1; m_fc = '0;
    endtask

    function automatic logic [44:0] dut_obs();
        return {m_axis_tvalid, m_axis_tvalid ? {m_axis_tlast, m_axis_tuser, m_axis_tdata} : 26'h0,
                ready_out, overflow, frame_count};
    endfunction

    function automatic logic [44:0] model_obs();
        return {mq.size() != 0, (mq.size() != 0) ? mq[0] : 26'h0, m_rdy, m_ovf, m_fc};
    endfunction

    // Drive one cycle of inputs, then advance the model across the clock edge.
    task automatic step(input bit de, input bit fs, input bit le, input logic [23:0] d,
                        input bit rdy, input bit clr = 1'b0);
        bit hs, full, acc, drop;
        mstate_t nst;
        data_enable_in = de; frame_start_in = fs; line_end_in = le; data_in = d;
        m_axis_tready = rdy; clear_overflow = clr;
        if (m_axis_tvalid && rdy) hs_cnt++;
        hs   = (mq.size() != 0) && rdy;
        full = (mq.size() == DEPTH) && !hs;
        acc = 1'b0; drop = 1'b0; nst = m_st;
        if (de && (m_st == M_PASS || fs)) begin
            if (full) begin drop = 1'b1; nst = M_DROP; end
            else begin acc = 1'b1; nst = M_PASS; end
        end
        @(posedge clk); #1;
        if (hs) begin
            if (mq[0][24]) m_fc++;
            void'(mq.pop_front());
        end
        if (acc) mq.push_back({le, fs, d});
        if (drop) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_rdy = (mq.size() <= DEPTH - AF_MARGIN);
        m_st = nst;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        data_enable_in = 0; frame_start_in = 0; line_end_in = 0; data_in = '0;
        m_axis_tready = 0; clear_overflow = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_err++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        n_checks++;
        if ({m_axis_tlast, m_axis_tuser, m_axis_tdata} !== 26'h0) begin
            n_err++; $display("FAIL reset_data: got %h want 0", {m_axis_tlast, m_axis_tuser, m_axis_tdata});
        end
        n_checks++;
        if ({ready_out, overflow, frame_count} !== {1'b1, 1'b0, 16'h0}) begin
            n_err++; $display("FAIL reset_ctrl: got rdy=%b ovf=%b fc=%0d want 1 0 0", ready_out, overflow, frame_count);
        end
    endtask

    task automatic test_basic_frame();
        for (int i = 0; i < 12; i++) begin
            if (i < 8) step(1, i == 0, (i == 3) || (i == 7), 24'(i + 1), 1);
            else step(0, 0, 0, '0, 1);
            n_checks++;
            if (dut_obs() !== model_obs()) begin
                n_err++; $display("FAIL basic cyc%0d: got %h want %h", i, dut_obs(), model_obs());
            end
            if (i == 0) begin
                n_checks++;
                if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata} !== {2'b11, 24'h000001}) begin
                    n_err++; $display("FAIL basic_latency: got v=%b u=%b d=%h want 1 1 000001",
                                      m_axis_tvalid, m_axis_tuser, m_axis_tdata);
                end
            end
        end
        n_checks++;
        if (frame_count !== 16'd1) begin n_err++; $display("FAIL basic_fc: got %0d want 1", frame_count); end
    endtask

    task automatic test_pre_sof();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i < 3) step(1, 0, 0, 24'hAAAAAA, 1);
            else if (i < 6) step(1, i == 3, i == 5, 24'(16 + i - 3), 1);
            else step(0, 0, 0, '0, 1);
            n_checks++;
            if (dut_obs() !== model_obs()) begin
                n_err++; $display("FAIL pre_sof cyc%0d: got %h want %h", i, dut_obs(), model_obs());
            end
            if (i == 3) begin
                n_checks++;
                if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 24'h000010}) begin
                    n_err++; $display("FAIL pre_sof_first: got v=%b d=%h want 1 000010", m_axis_tvalid, m_axis_tdata);
                end
            end
        end
        n_checks++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL pre_sof_ovf: got %b want 0", overflow); end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1, i == 0, 0, 24'h100 + 24'(i), 0);
            n_checks++;
            if (dut_obs() !== model_obs()) begin
                n_err++; $display("FAIL fill cyc%0d: got %h want %h", i, dut_obs(), model_obs());
            end
        end
        n_checks++;
        if ({ready_out, overflow, m_axis_tdata} !== {1'b0, 1'b0, 24'h000100}) begin
            n_err++; $display("FAIL fill_full: got rdy=%b ovf=%b d=%h want 0 0 000100", ready_out, overflow, m_axis_tdata);
        end
        // 17th beat while full, with a simultaneous clear: set must win.
        step(1, 0, 0, 24'hBAD000, 0, 1);
        n_checks++;
        if (overflow !== 1'b1) begin n_err++; $display("FAIL overflow_set: got %b want 1", overflow); end
        step(1, 0, 1, 24'hBAD001, 0);
        step(1, 0, 0, 24'hBAD002, 1);
        step(1, 1, 0, 24'h123456, 1);
        step(1, 0, 1, 24'h123457, 1);
        for (int i = 0; i < 24 && mq.size() != 0; i++) begin
            step(0, 0, 0, '0, 1);
            n_checks++;
            if (dut_obs() !== model_obs()) begin
                n_err++; $display("FAIL drain cyc%0d: got %h want %h", i, dut_obs(), model_obs());
            end
        end
        n_checks++;
        if (mq.size() != 0 || m_axis_tvalid !== 1'b0) begin
            n_err++; $display("FAIL drain_done: got tvalid=%b left=%0d want 0 0", m_axis_tvalid, mq.size());
        end
        step(0, 0, 0, '0, 1, 1);
        n_checks++;
        if ({overflow, frame_count} !== {1'b0, 16'd2}) begin
            n_err++; $display("FAIL overflow_clear: got ovf=%b fc=%0d want 0 2", overflow, frame_count);
        end
    endtask

    task automatic test_random_frames();
        do_reset();
        hs_cnt = 0;
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < 256; p++) begin
                for (int g = 0; g < 200 && (!m_rdy || $urandom_range(3) == 0); g++) begin
                    step(0, 0, 0, 24'($urandom), 1'($urandom));
                    n_checks++;
                    if (dut_obs() !== model_obs()) begin
                        n_err++; $display("FAIL rand_idle f%0d p%0d: got %h want %h", f, p, dut_obs(), model_obs());
                    end
                end
                step(1, p == 0, (p % 64) == 63, 24'($urandom), 1'($urandom));
                n_checks++;
                if (dut_obs() !== model_obs()) begin
                    n_err++; $display("FAIL rand_beat f%0d p%0d: got %h want %h", f, p, dut_obs(), model_obs());
                end
            end
        for (int i = 0; i < 400 && mq.size() != 0; i++) begin
            step(0, 0, 0, '0, 1'($urandom));
            n_checks++;
            if (dut_obs() !== model_obs()) begin
                n_err++; $display("FAIL rand_drain cyc%0d: got %h want %h", i, dut_obs(), model_obs());
            end
        end
        step(0, 0, 0, '0, 1);
        n_checks++;
        if ({frame_count, overflow, m_axis_tvalid} !== {16'd3, 1'b0, 1'b0} || hs_cnt != 768) begin
            n_err++; $display("FAIL rand_totals: got fc=%0d ovf=%b v=%b beats=%0d want 3 0 0 768",
                              frame_count, overflow, m_axis_tvalid, hs_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int i = 0; i < 5; i++) step(1, i == 0, 0, 24'h500 + 24'(i), 0);
        n_checks++;
        if ({m_axis_tvalid, frame_count} !== {1'b1, 16'd3}) begin
            n_err++; $display("FAIL mid_pre: got v=%b fc=%0d want 1 3", m_axis_tvalid, frame_count);
        end
        #2 resetn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({m_axis_tvalid, frame_count, ready_out} !== {1'b0, 16'd0, 1'b1}) begin
            n_err++; $display("FAIL mid_reset: got v=%b fc=%0d rdy=%b want 0 0 1", m_axis_tvalid, frame_count, ready_out);
        end
        @(posedge clk); #1 resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) step(1, 0, 0, 24'h600 + 24'(i), 1);
            else if (i == 3) step(1, 1, 1, 24'h000777, 1);
            else step(0, 0, 0, '0, 1);
            n_checks++;
            if (dut_obs() !== model_obs()) begin
                n_err++; $display("FAIL mid_post cyc%0d: got %h want %h", i, dut_obs(), model_obs());
            end
        end
        n_checks++;
        if (frame_count !== 16'd1) begin n_err++; $display("FAIL mid_fc: got %0d want 1", frame_count); end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_pre_sof();
        test_fill_overflow();
        test_random_frames();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
